// File: rtl/clkdiv_pkg.sv
// Shared types and constants for the clock divider controller and its arbiter.
// Also provides the index-width helper used by every requester-indexed vector.
package clkdiv_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    localparam int MIN_DIV   = 2;
    localparam int DEFAULT_N = 8;

    // A single requester still needs a one-bit index so vectors stay legal.
    function automatic int ptr_width(input int num);
        return (num > 1) ? $clog2(num) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after the rotating pointer.
// The pointer advances past the granted index when the owner signals a transfer.
module rr_arbiter
    import clkdiv_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = ptr_width(NUM_REQ)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_enable,
    input  logic               i_update,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_grant_idx,
    output logic               o_grant_valid
);

    logic [IDX_W-1:0]   r_ptr;
    logic [NUM_REQ-1:0] w_grant;
    logic [IDX_W-1:0]   w_idx;
    logic               w_found;

    always_comb begin
        w_grant = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int off = 0; off < NUM_REQ; off++) begin
            int cand;
            cand = int'(r_ptr) + off;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (i_enable && !w_found && i_req[IDX_W'(cand)]) begin
                w_found                = 1'b1;
                w_grant[IDX_W'(cand)]  = 1'b1;
                w_idx                  = IDX_W'(cand);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else if (i_update) begin
            r_ptr <= (w_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_idx + IDX_W'(1);
        end
    end

    assign o_grant       = w_grant;
    assign o_grant_idx   = w_idx;
    assign o_grant_valid = w_found;

endmodule

// File: rtl/clock_divider_ctrl.sv
// Run-time divider controller: arbitrates divisor updates, owns the divide
// counter and start/stop sequencing, and swaps divisors only on period boundaries.
module clock_divider_ctrl
    import clkdiv_pkg::*;
#(
    parameter int N           = DEFAULT_N,
    parameter int NUM_REQ     = 2,
    parameter int DEFAULT_DIV = 2
) (
    input  logic                 clock_in,
    input  logic                 reset_n,
    input  logic                 run,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*N-1:0] req_divisor,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 clock_out,
    output logic                 tick,
    output logic [N-1:0]         active_divisor,
    output logic                 busy,
    output logic                 err
);

    localparam int IDX_W = ptr_width(NUM_REQ);

    state_t           r_state;
    logic [N-1:0]     r_counter;
    logic [N-1:0]     r_active;
    logic [N-1:0]     r_pending;
    logic             r_busy;
    logic             r_err;
    logic             r_clk_out;
    logic             r_tick;

    logic [NUM_REQ-1:0] w_grant;
    logic [IDX_W-1:0]   w_grant_idx;
    logic               w_grant_valid;
    logic [N-1:0]       w_req_div [NUM_REQ];
    logic [N-1:0]       w_sel_div;
    logic               w_div_ok;
    logic               w_transfer;
    logic               w_boundary;
    logic               w_apply;
    logic               w_running_next;
    logic [N-1:0]       w_counter_next;
    logic [N-1:0]       w_active_next;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .i_clk         (clock_in),
        .i_rst_n       (reset_n),
        .i_req         (req_valid),
        .i_enable      (!r_busy),
        .i_update      (w_transfer),
        .o_grant       (w_grant),
        .o_grant_idx   (w_grant_idx),
        .o_grant_valid (w_grant_valid)
    );

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
        assign w_req_div[gi] = req_divisor[gi*N +: N];
    end

    assign w_sel_div  = w_req_div[w_grant_idx];
    assign w_div_ok   = (w_sel_div >= N'(MIN_DIV));
    assign w_transfer = w_grant_valid;
    assign w_boundary = (r_counter == r_active - N'(1));
    // A pending divisor lands on the wrap edge, or straight away when stopped.
    assign w_apply    = r_busy && ((r_state == IDLE) || w_boundary);

    always_comb begin
        w_active_next  = w_apply ? r_pending : r_active;
        w_running_next = 1'b0;
        case (r_state)
            IDLE:     w_running_next = run;
            RUN:      w_running_next = run || !w_boundary;
            STOPPING: w_running_next = run || !w_boundary;
            default:  w_running_next = 1'b0;
        endcase
        w_counter_next = '0;
        if ((r_state != IDLE) && !w_boundary) begin
            w_counter_next = r_counter + N'(1);
        end
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_counter <= '0;
            r_active  <= N'(DEFAULT_DIV);
            r_pending <= '0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            case (r_state)
                IDLE:     if (run) r_state <= RUN;
                // Dropping run exactly on the last cycle ends the period right here.
                RUN:      if (!run) r_state <= w_boundary ? IDLE : STOPPING;
                STOPPING: begin
                    if (run) begin
                        r_state <= RUN;
                    end else if (w_boundary) begin
                        r_state <= IDLE;
                    end
                end
                default:  r_state <= IDLE;
            endcase

            r_counter <= w_counter_next;
            r_active  <= w_active_next;
            r_clk_out <= w_running_next && (w_counter_next < (w_active_next >> 1));
            r_tick    <= w_running_next && (w_counter_next == '0);
            r_err     <= w_transfer && !w_div_ok;

            if (w_transfer && w_div_ok) begin
                r_pending <= w_sel_div;
                r_busy    <= 1'b1;
            end else if (w_apply) begin
                r_busy    <= 1'b0;
            end
        end
    end

    assign req_ready      = w_grant;
    assign clock_out      = r_clk_out;
    assign tick           = r_tick;
    assign active_divisor = r_active;
    assign busy           = r_busy;
    assign err            = r_err;

endmodule

// File: tb/tb_clock_divider_ctrl.sv
// Directed cycle vectors for clock_divider_ctrl; a negedge monitor pops the
// hand-computed expected outputs of each cycle from a scoreboard queue.
module tb_clock_divider_ctrl;

    logic        clk;
    logic        reset_n;
    logic        run;
    logic [1:0]  req_valid;
    logic [15:0] req_divisor;
    logic [1:0]  req_ready;
    logic        clock_out;
    logic        tick;
    logic [7:0]  active_divisor;
    logic        busy;
    logic        err;

    clock_divider_ctrl #(
        .N           (8),
        .NUM_REQ     (2),
        .DEFAULT_DIV (2)
    ) dut (
        .clock_in       (clk),
        .reset_n        (reset_n),
        .run            (run),
        .req_valid      (req_valid),
        .req_divisor    (req_divisor),
        .req_ready      (req_ready),
        .clock_out      (clock_out),
        .tick           (tick),
        .active_divisor (active_divisor),
        .busy           (busy),
        .err            (err)
    );

    // Packed expectation: {clock_out, tick, busy, err, req_ready[1:0], active_divisor[7:0]}
    typedef struct {
        int          id;
        logic [13:0] v;
    } exp_t;

    exp_t exp_q [$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   row_n    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs for one cycle are applied just after the rising edge; the
    // expectation describes what the monitor sees at the following falling edge.
    task automatic vec(input logic rst, input logic rn, input logic [1:0] vld,
                       input logic [7:0] d0, input logic [7:0] d1,
                       input logic co, input logic tk, input logic bz, input logic er,
                       input logic [1:0] rdy, input logic [7:0] ad);
        exp_t e;
        @(posedge clk);
        #1;
        reset_n     = rst;
        run         = rn;
        req_valid   = vld;
        req_divisor = {d1, d0};
        e.id = row_n;
        e.v  = {co, tk, bz, er, rdy, ad};
        exp_q.push_back(e);
        row_n++;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if ({clock_out, tick, busy, err, req_ready, active_divisor} !== mon_e.v) begin
                failures++;
                $display("FAIL row %0d outputs: got co=%0b tk=%0b busy=%0b err=%0b rdy=%b div=%0d, want co=%0b tk=%0b busy=%0b err=%0b rdy=%b div=%0d",
                         mon_e.id, clock_out, tick, busy, err, req_ready, active_divisor,
                         mon_e.v[13], mon_e.v[12], mon_e.v[11], mon_e.v[10], mon_e.v[9:8], mon_e.v[7:0]);
            end else begin
                $display("row %0d ok: co=%0b tk=%0b busy=%0b err=%0b rdy=%b div=%0d",
                         mon_e.id, clock_out, tick, busy, err, req_ready, active_divisor);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n     = 1'b0;
        run         = 1'b0;
        req_valid   = 2'b00;
        req_divisor = 16'h0;

        //   rst run vld    d0 d1   co tk bz er rdy    div
        // Reset, then run with the default divisor of 2
        vec(0, 0, 2'b00, 0, 0,   0, 0, 0, 0, 2'b00, 2);   // 0
        vec(0, 0, 2'b00, 0, 0,   0, 0, 0, 0, 2'b00, 2);   // 1
        vec(1, 0, 2'b00, 0, 0,   0, 0, 0, 0, 2'b00, 2);   // 2
        vec(1, 1, 2'b00, 0, 0,   0, 0, 0, 0, 2'b00, 2);   // 3 run sampled at end
        vec(1, 1, 2'b00, 0, 0,   1, 1, 0, 0, 2'b00, 2);   // 4
        vec(1, 1, 2'b00, 0, 0,   0, 0, 0, 0, 2'b00, 2);   // 5
        vec(1, 1, 2'b00, 0, 0,   1, 1, 0, 0, 2'b00, 2);   // 6
        // Request 4 on a boundary cycle: applied one period later
        vec(1, 1, 2'b01, 4, 0,   0, 0, 0, 0, 2'b01, 2);   // 7
        vec(1, 1, 2'b00, 0, 0,   1, 1, 1, 0, 2'b00, 2);   // 8
        vec(1, 1, 2'b00, 0, 0,   0, 0, 1, 0, 2'b00, 2);   // 9
        // Req0 sends 6 at counter 0 of D=4
        vec(1, 1, 2'b01, 6, 0,   1, 1, 0, 0, 2'b01, 4);   // 10
        vec(1, 1, 2'b00, 0, 0,   1, 0, 1, 0, 2'b00, 4);   // 11
        vec(1, 1, 2'b00, 0, 0,   0, 0, 1, 0, 2'b00, 4);   // 12
        vec(1, 1, 2'b00, 0, 0,   0, 0, 1, 0, 2'b00, 4);   // 13
        vec(1, 1, 2'b00, 0, 0,   1, 1, 0, 0, 2'b00, 6);   // 14
        vec(1, 1, 2'b00, 0, 0,   1, 0, 0, 0, 2'b00, 6);   // 15
        vec(1, 1, 2'b00, 0, 0,   1, 0, 0, 0, 2'b00, 6);   // 16
        vec(1, 1, 2'b00, 0, 0,   0, 0, 0, 0, 2'b00, 6);   // 17
        vec(1, 1, 2'b00, 0, 0,   0, 0, 0, 0, 2'b00, 6);   // 18
        vec(1, 1, 2'b00, 0, 0,   0, 0, 0, 0, 2'b00, 6);   // 19
        // Req1 sends 1: error pulse only
        vec(1, 1, 2'b10, 0, 1,   1, 1, 0, 0, 2'b10, 6);   // 20
        vec(1, 1, 2'b00, 0, 0,   1, 0, 0, 1, 2'b00, 6);   // 21
        // Both request (5, 7) with pointer at 0
        vec(1, 1, 2'b11, 5, 7,   1, 0, 0, 0, 2'b01, 6);   // 22
        vec(1, 1, 2'b10, 0, 7,   0, 0, 1, 0, 2'b00, 6);   // 23
        vec(1, 1, 2'b10, 0, 7,   0, 0, 1, 0, 2'b00, 6);   // 24
        vec(1, 1, 2'b10, 0, 7,   0, 0, 1, 0, 2'b00, 6);   // 25
        vec(1, 1, 2'b10, 0, 7,   1, 1, 0, 0, 2'b10, 5);   // 26
        vec(1, 1, 2'b00, 0, 0,   1, 0, 1, 0, 2'b00, 5);   // 27
        vec(1, 1, 2'b00, 0, 0,   0, 0, 1, 0, 2'b00, 5);   // 28
        vec(1, 1, 2'b00, 0, 0,   0, 0, 1, 0, 2'b00, 5);   // 29
        vec(1, 1, 2'b00, 0, 0,   0, 0, 1, 0, 2'b00, 5);   // 30
        // Pointer back at 0; equal-divisor update 7 from req0, req1 waits with 5
        vec(1, 1, 2'b11, 7, 5,   1, 1, 0, 0, 2'b01, 7);   // 31
        vec(1, 1, 2'b10, 0, 5,   1, 0, 1, 0, 2'b00, 7);   // 32
        vec(1, 1, 2'b10, 0, 5,   1, 0, 1, 0, 2'b00, 7);   // 33
        vec(1, 1, 2'b10, 0, 5,   0, 0, 1, 0, 2'b00, 7);   // 34
        vec(1, 1, 2'b10, 0, 5,   0, 0, 1, 0, 2'b00, 7);   // 35
        vec(1, 1, 2'b10, 0, 5,   0, 0, 1, 0, 2'b00, 7);   // 36
        vec(1, 1, 2'b10, 0, 5,   0, 0, 1, 0, 2'b00, 7);   // 37
        vec(1, 1, 2'b10, 0, 5,   1, 1, 0, 0, 2'b10, 7);   // 38
        vec(1, 1, 2'b00, 0, 0,   1, 0, 1, 0, 2'b00, 7);   // 39
        vec(1, 1, 2'b00, 0, 0,   1, 0, 1, 0, 2'b00, 7);   // 40
        vec(1, 1, 2'b00, 0, 0,   0, 0, 1, 0, 2'b00, 7);   // 41
        vec(1, 1, 2'b00, 0, 0,   0, 0, 1, 0, 2'b00, 7);   // 42
        vec(1, 1, 2'b00, 0, 0,   0, 0, 1, 0, 2'b00, 7);   // 43
        vec(1, 1, 2'b00, 0, 0,   0, 0, 1, 0, 2'b00, 7);   // 44
        vec(1, 1, 2'b00, 0, 0,   1, 1, 0, 0, 2'b00, 5);   // 45
        // D=5, run dropped at counter 1: finish period, then idle
        vec(1, 0, 2'b00, 0, 0,   1, 0, 0, 0, 2'b00, 5);   // 46
        vec(1, 0, 2'b00, 0, 0,   0, 0, 0, 0, 2'b00, 5);   // 47
        vec(1, 0, 2'b00, 0, 0,   0, 0, 0, 0, 2'b00, 5);   // 48
        vec(1, 0, 2'b00, 0, 0,   0, 0, 0, 0, 2'b00, 5);   // 49
        vec(1, 0, 2'b00, 0, 0,   0, 0, 0, 0, 2'b00, 5);   // 50
        vec(1, 1, 2'b00, 0, 0,   0, 0, 0, 0, 2'b00, 5);   // 51
        // Restart, then a one-cycle run drop that returns before the boundary
        vec(1, 0, 2'b00, 0, 0,   1, 1, 0, 0, 2'b00, 5);   // 52
        vec(1, 1, 2'b00, 0, 0,   1, 0, 0, 0, 2'b00, 5);   // 53
        vec(1, 1, 2'b00, 0, 0,   0, 0, 0, 0, 2'b00, 5);   // 54
        vec(1, 1, 2'b00, 0, 0,   0, 0, 0, 0, 2'b00, 5);   // 55
        vec(1, 1, 2'b00, 0, 0,   0, 0, 0, 0, 2'b00, 5);   // 56
        // Move to D=3, then make an update pending
        vec(1, 1, 2'b01, 3, 0,   1, 1, 0, 0, 2'b01, 5);   // 57
        vec(1, 1, 2'b00, 0, 0,   1, 0, 1, 0, 2'b00, 5);   // 58
        vec(1, 1, 2'b00, 0, 0,   0, 0, 1, 0, 2'b00, 5);   // 59
        vec(1, 1, 2'b00, 0, 0,   0, 0, 1, 0, 2'b00, 5);   // 60
        vec(1, 1, 2'b00, 0, 0,   0, 0, 1, 0, 2'b00, 5);   // 61
        vec(1, 1, 2'b01, 9, 0,   1, 1, 0, 0, 2'b01, 3);   // 62
        vec(1, 1, 2'b00, 0, 0,   0, 0, 1, 0, 2'b00, 3);   // 63
        // Asynchronous reset mid-period while busy
        vec(0, 1, 2'b00, 0, 0,   0, 0, 0, 0, 2'b00, 2);   // 64
        vec(0, 1, 2'b00, 0, 0,   0, 0, 0, 0, 2'b00, 2);   // 65
        vec(1, 0, 2'b00, 0, 0,   0, 0, 0, 0, 2'b00, 2);   // 66
        // Pointer reset to 0; updates in IDLE load on the next edge
        vec(1, 0, 2'b11, 4, 6,   0, 0, 0, 0, 2'b01, 2);   // 67
        vec(1, 0, 2'b10, 0, 6,   0, 0, 1, 0, 2'b00, 2);   // 68
        vec(1, 0, 2'b10, 0, 6,   0, 0, 0, 0, 2'b10, 4);   // 69
        vec(1, 0, 2'b00, 0, 0,   0, 0, 1, 0, 2'b00, 4);   // 70
        vec(1, 1, 2'b00, 0, 0,   0, 0, 0, 0, 2'b00, 6);   // 71
        vec(1, 1, 2'b00, 0, 0,   1, 1, 0, 0, 2'b00, 6);   // 72
        vec(1, 1, 2'b00, 0, 0,   1, 0, 0, 0, 2'b00, 6);   // 73

        @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
